// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: issues sequential ROM fetches and buffers {pc, inst}
// pairs in a small FIFO presented to the core under a valid/ready handshake.
module inst_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         rom_ce,
    output logic [31:0]                  rom_addr,
    input  logic [31:0]                  rom_inst,
    output logic                         inst_valid,
    output logic [31:0]                  inst_o,
    output logic [31:0]                  inst_pc,
    input  logic                         inst_ready,
    input  logic                         flush,
    input  logic [31:0]                  flush_pc,
    output logic [$clog2(DEPTH+1)-1:0]   q_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;

    logic [31:0]   fpc_q, fpc_d;
    ptr_t          rd_ptr_q, rd_ptr_d;
    ptr_t          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   mem_q [DEPTH];

    logic full;
    logic pop;
    logic push;

    assign full       = (count_q == CW'(DEPTH));
    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid & inst_ready & ~flush;
    // A full queue may still fetch when the head leaves in the same cycle.
    assign push       = rst & ~flush & (~full | pop);

    assign rom_ce   = push;
    assign rom_addr = fpc_q;
    assign inst_pc  = mem_q[rd_ptr_q][63:32];
    assign inst_o   = mem_q[rd_ptr_q][31:0];
    assign q_count  = count_q;

    always_comb begin
        fpc_d    = fpc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            fpc_d    = {flush_pc[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_t'(wr_ptr_q + 1'b1);
                fpc_d    = fpc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = ptr_t'(rd_ptr_q + 1'b1);
            end
            if (push && !pop) begin
                count_d = CW'(count_q + 1'b1);
            end else if (pop && !push) begin
                count_d = CW'(count_q - 1'b1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc_q    <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fpc_q    <= fpc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {fpc_q, rom_inst};
        end
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Randomised bench for inst_prefetch_queue: a queue-based fetch model feeds a
// scoreboard that a negedge monitor drains on every handshake.
module tb_inst_prefetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        inst_valid;
    logic [31:0] inst_o;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        flush;
    logic [31:0] flush_pc;
    logic [2:0]  q_count;

    int checks   = 0;
    int failures = 0;

    inst_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce     (rom_ce),
        .rom_addr   (rom_addr),
        .rom_inst   (rom_inst),
        .inst_valid (inst_valid),
        .inst_o     (inst_o),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .q_count    (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return 32'hA000_0000 + (addr >> 2);
    endfunction

    assign rom_inst = rom_word(rom_addr);

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: what the fetch stage should hold, as a plain queue.
    logic [63:0] sb[$];
    int          m_count = 0;
    logic [31:0] m_fpc   = RESET_PC;

    always @(negedge rst) begin
        sb.delete();
        m_count = 0;
        m_fpc   = RESET_PC;
    end

    always @(posedge clk) begin : model
        bit p;
        bit q;
        if (rst) begin
            q = (m_count != 0) && inst_ready && !flush;
            p = !flush && (m_count < int'(DEPTH) || q);
            if (flush) begin
                m_count = 0;
                sb.delete();
                m_fpc = {flush_pc[31:2], 2'b00};
            end else begin
                if (p) begin
                    sb.push_back({m_fpc, rom_word(m_fpc)});
                    m_fpc = m_fpc + 32'd4;
                end
                m_count = m_count + int'(p) - int'(q);
            end
        end
    end

    always @(negedge clk) begin : monitor
        bit exp_ce;
        exp_ce = rst && !flush && (m_count < int'(DEPTH) || (m_count != 0 && inst_ready));
        chk("rom_ce", {31'b0, rom_ce}, {31'b0, exp_ce});
        chk("rom_addr", rom_addr, m_fpc);
        chk("q_count", {29'b0, q_count}, m_count);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, sb.size() != 0});
        if (sb.size() != 0) begin
            chk("head_pc", inst_pc, sb[0][63:32]);
            chk("head_inst", inst_o, sb[0][31:0]);
        end
        if (rst && inst_valid && inst_ready && !flush) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_empty: got handshake expected no entry at %0t", $time);
            end else begin
                void'(sb.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; rst low for 3 ns, released well before the negedge.
    task automatic pulse_rst();
        rst = 1'b0;
        #1;
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_ce", {31'b0, rom_ce}, 32'd0);
        chk("rst_count", {29'b0, q_count}, 32'd0);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        rst        = 1'b0;
        inst_ready = 1'b0;
        flush      = 1'b0;
        flush_pc   = 32'h0;
        repeat (2) cyc();
        chk("reset_valid", {31'b0, inst_valid}, 32'd0);
        chk("reset_ce", {31'b0, rom_ce}, 32'd0);
        chk("reset_count", {29'b0, q_count}, 32'd0);
        rst = 1'b1;

        // Fill with no consumer.
        repeat (4) cyc();
        @(negedge clk);
        chk("fill_count", {29'b0, q_count}, 32'd4);
        chk("fill_ce", {31'b0, rom_ce}, 32'd0);
        chk("fill_addr", rom_addr, 32'd16);
        chk("fill_pc", inst_pc, 32'd0);
        chk("fill_inst", inst_o, 32'hA000_0000);

        // Single pop while full still fetches.
        cyc();
        inst_ready = 1'b1;
        @(negedge clk);
        chk("fullpop_ce", {31'b0, rom_ce}, 32'd1);
        cyc();
        inst_ready = 1'b0;
        @(negedge clk);
        chk("fullpop_count", {29'b0, q_count}, 32'd4);
        chk("fullpop_pc", inst_pc, 32'd4);

        // Flush with a full queue and a ready core.
        cyc();
        flush      = 1'b1;
        flush_pc   = 32'h0000_0103;
        inst_ready = 1'b1;
        @(negedge clk);
        chk("flush_ce", {31'b0, rom_ce}, 32'd0);
        cyc();
        flush      = 1'b0;
        inst_ready = 1'b0;
        @(negedge clk);
        chk("flush_count", {29'b0, q_count}, 32'd0);
        chk("flush_valid", {31'b0, inst_valid}, 32'd0);
        chk("flush_addr", rom_addr, 32'h100);
        chk("flush_ce1", {31'b0, rom_ce}, 32'd1);
        cyc();
        @(negedge clk);
        chk("flush_head", inst_pc, 32'h100);

        // Streaming after an asynchronous reset.
        cyc();
        inst_ready = 1'b1;
        pulse_rst();
        repeat (6) cyc();
        @(negedge clk);
        chk("stream_count", {29'b0, q_count}, 32'd1);
        chk("stream_valid", {31'b0, inst_valid}, 32'd1);

        // Fetch PC wraps past the top of the address space.
        cyc();
        flush    = 1'b1;
        flush_pc = 32'hFFFF_FFFC;
        cyc();
        flush = 1'b0;
        @(negedge clk);
        chk("wrap_a0", rom_addr, 32'hFFFF_FFFC);
        cyc();
        @(negedge clk);
        chk("wrap_a1", rom_addr, 32'h0000_0000);
        cyc();
        @(negedge clk);
        chk("wrap_a2", rom_addr, 32'h0000_0004);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            inst_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            flush_pc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                     : $urandom;
            if ($urandom_range(0, 299) == 0) begin
                pulse_rst();
            end
        end
        cyc();
        flush      = 1'b0;
        inst_ready = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
